imm_enc: RTL and testbench
==========================

Name: imm_enc

Overview:
- Streaming immediate encoder: the inverse of the decode-side sign extender.
- Takes a base instruction word, a 32-bit immediate and an ImmSrc format code. Scatters the immediate into that format's bit positions and flags values the format cannot represent.
- Sits between the program loader / self-test generator and instruction memory. Emits a write address with each encoded word.

Parameters:
- ADDR_W, 10, width of instruction-memory word address counter (wraps at 2^ADDR_W)
- ERR_W, 8, width of saturating range-error counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept request
- ImmSrc  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, others invalid
- Imm  in  32  immediate value (byte offset for B/J)
- Base  in  32  instruction with opcode/rd/rs/funct fields; immediate bit positions ignored
- out_valid  out  1  encoded word valid
- out_ready  in  1  downstream accepts
- Instr  out  32  encoded instruction
- RangeErr  out  1  Imm not representable in format, or invalid ImmSrc
- Addr  out  ADDR_W  word address for Instr
- ErrCount  out  ERR_W  saturating count of RangeErr words handed off

Behaviour:
- Reset values: out_valid=0, Instr=0, RangeErr=0, Addr=0, ErrCount=0. in_ready=1 in the cycle after reset.
- Pipeline: two register stages (S1 = pack+check, S2 = output), latency 2 cycles with no stall.
- Per-stage valid/ready: a stage loads when it is empty or its contents move on in the same cycle.
  - in_ready = !S1.valid || (!S2.valid || out_ready).
  - Full throughput of 1 word/cycle under continuous out_ready.
- Handshake: a transfer occurs on valid&&ready at the rising edge.
  - While out_valid=1 && out_ready=0, Instr, RangeErr and Addr hold stable.
  - in_valid may drop without a handshake; no request is consumed unless in_ready=1.
- Packing: bits outside the immediate positions come from Base; immediate positions are overwritten.
  - I: [31:20]=Imm[11:0]
  - S: [31:25]=Imm[11:5], [11:7]=Imm[4:0]
  - B: [31]=Imm[12], [7]=Imm[11], [30:25]=Imm[10:5], [11:8]=Imm[4:1]
  - J: [31]=Imm[20], [19:12]=Imm[19:12], [20]=Imm[11], [30:21]=Imm[10:1]
  - U: [31:12]=Imm[31:12]
  - Invalid ImmSrc: Instr=Base unchanged.
- Range check (RangeErr=1 when violated):
  - I/S: Imm[31:11] all equal.
  - B: Imm[31:12] all equal, and Imm[0]=0.
  - J: Imm[31:20] all equal, and Imm[0]=0.
  - U: Imm[11:0]=0.
  - Invalid ImmSrc: always error.
- On error the truncated bits are still packed and the word is still emitted with its Addr. No request is dropped.
- Round-trip invariant: if RangeErr=0, sign-extend-decoding Instr with the same ImmSrc returns Imm exactly.
- Addr: the value presented is the current counter. The counter increments by 1 on each output handshake and wraps from 2^ADDR_W-1 to 0.
- ErrCount: increments on an output handshake with RangeErr=1 and saturates at 2^ERR_W-1.
- Reset mid-operation: in-flight words are discarded, counters clear, and nothing is emitted in the reset cycle or the cycle after it.

Decomposition:
- Shared package holds:
  - ImmSrc encodings IMM_I=3'b000, IMM_S=3'b001, IMM_B=3'b010, IMM_J=3'b011, IMM_U=3'b100. The decode-side sign extender and control unit use the same package.
  - Request struct {ImmSrc, Imm, Base}.
- One sub-module, imm_pack: purely combinational packing + range check with outputs Instr, RangeErr. It is reused by the test bench as a golden model.

Test Plan:
- I: Base=0x00000093, ImmSrc=0, Imm=0xFFFFFFFF -> Instr=0xFFF00093, RangeErr=0, Addr=0, 2 cycles after accept.
- S/B: Base=0x0020A023, ImmSrc=1, Imm=8 -> 0x0020A423. Then Base=0x00000063, ImmSrc=2, Imm=0xFFFFFFFC -> 0xFE000EE3, Addr=1.
- J/U/errors:
  - Base=0x000000EF, ImmSrc=3, Imm=0x800 -> 0x001000EF.
  - Base=0x000002B7, ImmSrc=4, Imm=0x12345000 -> 0x123452B7.
  - Imm=0x12345001 -> RangeErr=1, ErrCount=1.
  - ImmSrc=0, Imm=2048 -> RangeErr=1, Instr=0x80000000|Base.
  - ImmSrc=7 -> Instr=Base, RangeErr=1.
- Backpressure: stream 5 requests, hold out_ready=0 for 4 cycles -> in_ready drops after 2 accepted; outputs stay stable; all 5 emerge in order with Addr 0..4 and no loss or duplication.
- Wrap/saturation: 2^ADDR_W+1 handshakes -> final Addr=0 then 1. 300 error words with ERR_W=8 -> ErrCount=255.
- Reset with both stages full -> out_valid=0 the next cycle, Addr=0, ErrCount=0. First post-reset request gets Addr=0.

Source files
------------

// File: rtl/imm_enc_pkg.sv
// Shared immediate-format definitions for the encoder, the decode-side
// sign extender and the control unit.
package imm_enc_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic [2:0]  imm_src;
        logic [31:0] imm;
        logic [31:0] base;
    } imm_req_t;

    // True when v[31:msb] are all equal, i.e. v survives truncation to msb+1
    // bits followed by sign extension.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
        logic [31:0] s;
        s = $signed(v) >>> msb;
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate scatter plus representability check for one
// instruction word; bits outside the immediate field come from Base.
module imm_pack
    import imm_enc_pkg::*;
(
    input  logic [2:0]  ImmSrc,
    input  logic [31:0] Imm,
    input  logic [31:0] Base,
    output logic [31:0] Instr,
    output logic        RangeErr
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        Instr    = Base;
        RangeErr = 1'b1;
        case (ImmSrc)
            IMM_I: begin
                Instr[31:20] = Imm[11:0];
                RangeErr     = !fits_signed(Imm, 11);
            end
            IMM_S: begin
                Instr[31:25] = Imm[11:5];
                Instr[11:7]  = Imm[4:0];
                RangeErr     = !fits_signed(Imm, 11);
            end
            IMM_B: begin
                Instr[31]    = Imm[12];
                Instr[7]     = Imm[11];
                Instr[30:25] = Imm[10:5];
                Instr[11:8]  = Imm[4:1];
                RangeErr     = !fits_signed(Imm, 12) || Imm[0];
            end
            IMM_J: begin
                Instr[31]    = Imm[20];
                Instr[19:12] = Imm[19:12];
                Instr[20]    = Imm[11];
                Instr[30:21] = Imm[10:1];
                RangeErr     = !fits_signed(Imm, 20) || Imm[0];
            end
            IMM_U: begin
                Instr[31:12] = Imm[31:12];
                RangeErr     = |Imm[11:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_enc.sv
// Two-stage streaming immediate encoder: S1 packs and range-checks, S2 holds
// the output word, which is tagged with an instruction-memory write address.
module imm_enc
    import imm_enc_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        ImmSrc,
    input  logic [31:0]       Imm,
    input  logic [31:0]       Base,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       Instr,
    output logic              RangeErr,
    output logic [ADDR_W-1:0] Addr,
    output logic [ERR_W-1:0]  ErrCount
);

    imm_req_t    req;
    logic [31:0] pack_instr;
    logic        pack_err;

    logic        s1_valid;
    logic [31:0] s1_instr;
    logic        s1_err;

    logic        s1_ready;
    logic        s2_ready;
    logic        out_fire;

    assign req = '{imm_src: ImmSrc, imm: Imm, base: Base};

    imm_pack u_pack (
        .ImmSrc  (req.imm_src),
        .Imm     (req.imm),
        .Base    (req.base),
        .Instr   (pack_instr),
        .RangeErr(pack_err)
    );

    // A stage may load when empty or when its word leaves in the same cycle.
    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            s1_valid  <= 1'b0;
            s1_instr  <= '0;
            s1_err    <= 1'b0;
            out_valid <= 1'b0;
            Instr     <= '0;
            RangeErr  <= 1'b0;
            Addr      <= '0;
            ErrCount  <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_instr <= pack_instr;
                    s1_err   <= pack_err;
                end
            end
            if (s2_ready) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    Instr    <= s1_instr;
                    RangeErr <= s1_err;
                end
            end
            if (out_fire) begin
                Addr <= Addr + 1'b1;
                if (RangeErr && (ErrCount != '1)) begin
                    ErrCount <= ErrCount + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_enc.sv
// Scoreboard bench for imm_enc: the driver queues hand-computed expected
// words, an independent monitor pops and compares on every output handshake.
module tb_imm_enc;

    localparam int ADDR_W = 10;
    localparam int ERR_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        ImmSrc;
    logic [31:0]       Imm;
    logic [31:0]       Base;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       Instr;
    logic              RangeErr;
    logic [ADDR_W-1:0] Addr;
    logic [ERR_W-1:0]  ErrCount;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t              q[$];
    logic [ADDR_W-1:0] exp_addr;
    int                exp_err;
    int                checks   = 0;
    int                failures = 0;
    int                sent     = 0;

    imm_enc #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ImmSrc   (ImmSrc),
        .Imm      (Imm),
        .Base     (Base),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Instr    (Instr),
        .RangeErr (RangeErr),
        .Addr     (Addr),
        .ErrCount (ErrCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", name, act, want);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the accept.
    task automatic send(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base,
                        input logic [31:0] want_instr, input logic want_err);
        int waited = 0;
        exp_t e;
        ImmSrc   = src;
        Imm      = imm;
        Base     = base;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            e.instr = want_instr;
            e.err   = want_err;
            q.push_back(e);
            sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        q.delete();
        exp_addr = '0;
        exp_err  = 0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr", Instr, 32'd0);
        check("rst_range_err", 32'(RangeErr), 32'd0);
        check("rst_addr", 32'(Addr), 32'd0);
        check("rst_err_count", 32'(ErrCount), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Monitor: samples just after the falling edge, when the driver has settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_word", 32'(out_valid), 32'd0);
                end else begin
                    e = q[0];
                    check("instr", Instr, e.instr);
                    check("range_err", 32'(RangeErr), 32'(e.err));
                    check("addr", 32'(Addr), 32'(exp_addr));
                    check("err_count", 32'(ErrCount), exp_err);
                    if (out_ready) begin
                        void'(q.pop_front());
                        exp_addr = exp_addr + 1'b1;
                        if (e.err && exp_err < 255) exp_err++;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ImmSrc    = '0;
        Imm       = '0;
        Base      = '0;
        exp_addr  = '0;
        exp_err   = 0;
        @(negedge clk);
        do_reset();

        // I-format with two-cycle latency
        send(3'd0, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0);
        check("latency_s1_only", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_out_valid", 32'(out_valid), 32'd1);
        drain();

        do_reset();
        send(3'd1, 32'h0000_0008, 32'h0020_A023, 32'h0020_A423, 1'b0);
        send(3'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
        send(3'd3, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0);
        send(3'd4, 32'h1234_5000, 32'h0000_02B7, 32'h1234_52B7, 1'b0);
        send(3'd4, 32'h1234_5001, 32'h0000_02B7, 32'h1234_52B7, 1'b1);
        send(3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
        send(3'd7, 32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        send(3'd2, 32'h0000_0005, 32'h0000_0063, 32'h0000_0263, 1'b1);
        send(3'd2, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0);
        send(3'd0, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0);
        send(3'd3, 32'h0010_0000, 32'h0000_00EF, 32'h8000_00EF, 1'b1);
        drain();
        check("directed_addr", 32'(Addr), 32'd11);
        check("directed_err_count", 32'(ErrCount), 32'd5);

        // Backpressure: five requests against a four-cycle output stall
        do_reset();
        sent      = 0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send(3'd0, 32'(i + 1), 32'h0000_0013, (32'(i + 1) << 20) | 32'h13, 1'b0);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_accepted", sent, 2);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_addr", 32'(Addr), 32'd5);

        // Reset with both stages full
        out_ready = 1'b0;
        send(3'd0, 32'h0000_0001, 32'h0000_0013, 32'h0010_0013, 1'b0);
        send(3'd0, 32'h0000_0002, 32'h0000_0013, 32'h0020_0013, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        do_reset();
        out_ready = 1'b1;
        send(3'd1, 32'h0000_0008, 32'h0020_A023, 32'h0020_A423, 1'b0);
        drain();
        check("post_rst_addr", 32'(Addr), 32'd1);

        // Address wrap and error-counter saturation
        do_reset();
        for (int i = 0; i < (1 << ADDR_W) + 1; i++) begin
            if (i < 300) begin
                send(3'd7, 32'(i), 32'(i), 32'(i), 1'b1);
            end else begin
                send(3'd0, 32'(i) & 32'h3FF, 32'h0000_0013, ((32'(i) & 32'h3FF) << 20) | 32'h13, 1'b0);
            end
        end
        drain();
        check("wrap_addr", 32'(Addr), 32'd1);
        check("sat_err_count", 32'(ErrCount), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
